// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared state encoding and defaults for the peripheral bus decoder.
package soc_bus_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ERR  = 2'd2;
  localparam logic [31:0] ERR_DATA_DEF  = 32'h6666_6666;
  localparam logic [15:0] BASE_PAGE_DEF = 16'h0040;
  localparam int WINDOW_PAGES = 16;
endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: counts WAIT cycles, flags the last allowed one.
// Only built with BUS_TIMEOUT_EN defined, the sole configuration that instantiates it.
`ifdef BUS_TIMEOUT_EN
module bus_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : en ? count_q + CW'(1) : count_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else count_q <= count_d;
  end
  assign expired = en && count_q == CW'(LIMIT - 1);
endmodule
`endif

// File: rtl/periph_bus_decoder.sv
// periph_bus_decoder: page decoder with IDLE/WAIT/ERR handshake to N_SLAVES slaves.
// Define BUS_TIMEOUT_EN to abort WAIT into ERR after TIMEOUT_CYCLES cycles.
module periph_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int          N_SLAVES       = 6,
  parameter logic [15:0] BASE_PAGE      = BASE_PAGE_DEF,
  parameter int          TIMEOUT_CYCLES = 15,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wmask,
  input  logic                  mem_rstrb,
  output logic [31:0]           mem_rdata,
  output logic                  mem_rbusy,
  output logic                  mem_wbusy,
  output logic [N_SLAVES-1:0]   s_cs,
  output logic                  s_rd,
  output logic                  s_wr,
  output logic [3:0]            s_wmask,
  input  logic [N_SLAVES*32-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]   s_ready,
  output logic                  err_flag,
  output logic [31:0]           err_addr,
  input  logic                  err_clr
);
  localparam int SW = $clog2(N_SLAVES);
  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d, dec_slot;
  logic [31:0] addr_q, addr_d, rdata_q, rdata_d, err_addr_q, err_addr_d;
  logic [3:0] wmask_q, wmask_d;
  logic rd_q, rd_d, wr_q, wr_d, err_flag_q, err_flag_d;
  logic [15:0] page, off;
  logic in_win, dec_mapped, is_wr, req, in_idle, in_wait, sel_ready, expired, err_set;
  logic [N_SLAVES-1:0][31:0] rdata_v;
  logic unused_wdata;
  assign unused_wdata = ^mem_wdata;
  assign rdata_v = s_rdata;
  assign page = mem_addr[31:16];
  assign off = page - BASE_PAGE;
  assign in_win = page >= BASE_PAGE && off < 16'(WINDOW_PAGES);
  assign dec_mapped = !in_win || off < 16'(N_SLAVES - 1);
  assign dec_slot = in_win ? SW'(off) + SW'(1) : '0;
  assign is_wr = |mem_wmask;
  assign req = mem_rstrb | is_wr;
  assign in_idle = state_q == ST_IDLE;
  assign in_wait = state_q == ST_WAIT;
  assign sel_ready = s_ready[slot_q];
`ifdef BUS_TIMEOUT_EN
  bus_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .resetn(resetn), .clear(!in_wait), .en(in_wait), .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    addr_d = addr_q;
    wmask_d = wmask_q;
    rd_d = rd_q;
    wr_d = wr_q;
    rdata_d = rdata_q;
    err_addr_d = err_addr_q;
    err_set = 1'b0;
    if (in_idle && req) begin
      addr_d = mem_addr;
      wmask_d = mem_wmask;
      wr_d = is_wr;
      rd_d = !is_wr;
      slot_d = dec_slot;
      state_d = dec_mapped ? ST_WAIT : ST_ERR;
      err_set = !dec_mapped;
    end else if (in_wait) begin
      state_d = sel_ready ? ST_IDLE : expired ? ST_ERR : ST_WAIT;
      rdata_d = sel_ready && rd_q ? rdata_v[slot_q] : rdata_q;
      err_set = !sel_ready && expired;
    end else if (!in_idle) begin
      state_d = ST_IDLE;
    end
    // Error data and address land on the edge entering ERR, set beats clear.
    rdata_d = err_set ? ERR_DATA : rdata_d;
    err_addr_d = err_set ? addr_d : err_addr_q;
    err_flag_d = err_set | (err_flag_q & !err_clr);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      slot_q <= '0;
      addr_q <= '0;
      wmask_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      rdata_q <= '0;
      err_addr_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      addr_q <= addr_d;
      wmask_q <= wmask_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
      err_addr_q <= err_addr_d;
      err_flag_q <= err_flag_d;
    end
  end
  assign s_cs = in_wait ? N_SLAVES'(1) << slot_q : '0;
  assign s_rd = in_wait & rd_q;
  assign s_wr = in_wait & wr_q;
  assign s_wmask = in_wait ? wmask_q : 4'h0;
  assign mem_wbusy = resetn & (in_idle ? is_wr : wr_q);
  assign mem_rbusy = resetn & (in_idle ? mem_rstrb & !is_wr : rd_q);
  assign mem_rdata = rdata_q;
  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
endmodule

// File: tb/tb_periph_bus_decoder.sv
// tb_periph_bus_decoder: directed checks of decode, handshake, errors and reset.
module tb_periph_bus_decoder;
  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata, err_addr;
  logic [3:0] mem_wmask = '0, s_wmask;
  logic mem_rstrb = 1'b0, mem_rbusy, mem_wbusy, s_rd, s_wr, err_flag, err_clr = 1'b0;
  logic [5:0] s_cs, s_ready = '0;
  logic [191:0] s_rdata;
  int checks = 0, passed = 0;

  periph_bus_decoder dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .s_cs(s_cs), .s_rd(s_rd),
    .s_wr(s_wr), .s_wmask(s_wmask), .s_rdata(s_rdata), .s_ready(s_ready),
    .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

  task automatic go;
    @(negedge clk);
  endtask

  task automatic test_reset;
    mem_rstrb = 1'b1;
    #1;
    checks++; if (s_cs !== 6'b0) $display("FAIL rst_cs: got %b want 000000", s_cs); else passed++;
    checks++; if (mem_rbusy !== 1'b0) $display("FAIL rst_rbusy: got %b want 0", mem_rbusy); else passed++;
    checks++; if (mem_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", mem_rdata); else passed++;
    checks++; if ({err_flag, err_addr} !== 33'h0) $display("FAIL rst_err: got %b/%h want 0/0", err_flag, err_addr); else passed++;
    go();
    mem_rstrb = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_read_ram;
    go();
    mem_addr = 32'h0000_0100; mem_rstrb = 1'b1; s_ready = 6'b000001;
    #1;
    checks++; if ({mem_rbusy, mem_wbusy, s_cs} !== 8'b10_000000) $display("FAIL ram_req: got rb=%b wb=%b cs=%b want 1 0 000000", mem_rbusy, mem_wbusy, s_cs); else passed++;
    go();
    mem_rstrb = 1'b0;
    #1;
    checks++; if ({s_cs, s_rd, mem_rbusy} !== 8'b000001_1_1) $display("FAIL ram_wait: got cs=%b rd=%b rb=%b want 000001 1 1", s_cs, s_rd, mem_rbusy); else passed++;
    go();
    #1;
    checks++; if (mem_rdata !== 32'h1000_0000) $display("FAIL ram_data: got %h want 10000000", mem_rdata); else passed++;
    checks++; if ({mem_rbusy, s_cs} !== 7'b0) $display("FAIL ram_done: got rb=%b cs=%b want 0 000000", mem_rbusy, s_cs); else passed++;
  endtask

  task automatic test_write_slot1;
    int n;
    go();
    s_ready = 6'b0; mem_addr = 32'h0040_0000; mem_wmask = 4'hF; mem_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if ({mem_wbusy, mem_rbusy} !== 2'b10) $display("FAIL wr_req: got wb=%b rb=%b want 1 0", mem_wbusy, mem_rbusy); else passed++;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      go();
      mem_wmask = 4'h0;
      s_ready = i == 0 ? 6'b111101 : i == 2 ? 6'b000010 : 6'b0;
      #1;
      if (s_cs == 6'b000010 && s_wr && !s_rd && s_wmask == 4'hF && mem_wbusy) n++;
    end
    checks++; if (n !== 3) $display("FAIL wr_wait_cycles: got %0d want 3", n); else passed++;
    go();
    s_ready = 6'b0;
    #1;
    checks++; if ({mem_wbusy, s_wr, s_cs} !== 8'b0) $display("FAIL wr_done: got wb=%b wr=%b cs=%b want 0 0 000000", mem_wbusy, s_wr, s_cs); else passed++;
    checks++; if (mem_rdata !== 32'h1000_0000) $display("FAIL wr_rdata_hold: got %h want 10000000", mem_rdata); else passed++;
  endtask

  task automatic test_unmapped;
    go();
    mem_addr = 32'h0046_0000; mem_rstrb = 1'b1; s_ready = 6'b111111;
    go();
    mem_rstrb = 1'b0;
    #1;
    checks++; if ({s_cs, s_rd, mem_rbusy} !== 8'b000000_0_1) $display("FAIL unm_err_state: got cs=%b rd=%b rb=%b want 000000 0 1", s_cs, s_rd, mem_rbusy); else passed++;
    checks++; if (mem_rdata !== 32'h6666_6666) $display("FAIL unm_rdata: got %h want 66666666", mem_rdata); else passed++;
    checks++; if ({err_flag, err_addr} !== {1'b1, 32'h0046_0000}) $display("FAIL unm_err: got %b/%h want 1/00460000", err_flag, err_addr); else passed++;
    go();
    #1;
    checks++; if ({mem_rbusy, err_flag} !== 2'b01) $display("FAIL unm_exit: got rb=%b flag=%b want 0 1", mem_rbusy, err_flag); else passed++;
  endtask

  task automatic test_decode;
    logic [31:0] addrs [5] = '{32'h0044_0010, 32'h0045_0000, 32'h003F_FFFC, 32'h0050_0000, 32'h004F_0000};
    logic [5:0]  cs_exp [5] = '{6'b100000, 6'b000000, 6'b000001, 6'b000001, 6'b000000};
    logic [31:0] rd_exp [5] = '{32'h6000_0005, 32'h6666_6666, 32'h1000_0000, 32'h1000_0000, 32'h6666_6666};
    s_ready = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      go();
      mem_addr = addrs[i]; mem_rstrb = 1'b1;
      go();
      mem_rstrb = 1'b0;
      #1;
      checks++; if (s_cs !== cs_exp[i]) $display("FAIL dec_cs[%0d]: got %b want %b", i, s_cs, cs_exp[i]); else passed++;
      go();
      #1;
      checks++; if (mem_rdata !== rd_exp[i]) $display("FAIL dec_rdata[%0d]: got %h want %h", i, mem_rdata, rd_exp[i]); else passed++;
    end
    s_ready = 6'b0;
  endtask

  task automatic test_err_clr;
    go();
    err_clr = 1'b1;
    go();
    err_clr = 1'b0;
    #1;
    checks++; if ({err_flag, err_addr} !== {1'b0, 32'h004F_0000}) $display("FAIL clr: got %b/%h want 0/004f0000", err_flag, err_addr); else passed++;
    go();
    err_clr = 1'b1; mem_addr = 32'h0047_0000; mem_rstrb = 1'b1;
    go();
    err_clr = 1'b0; mem_rstrb = 1'b0;
    #1;
    checks++; if ({err_flag, err_addr} !== {1'b1, 32'h0047_0000}) $display("FAIL clr_vs_set: got %b/%h want 1/00470000", err_flag, err_addr); else passed++;
    go();
    err_clr = 1'b1;
    go();
    err_clr = 1'b0;
    #1;
    checks++; if (err_flag !== 1'b0) $display("FAIL clr_again: got %b want 0", err_flag); else passed++;
  endtask

  task automatic test_timeout;
    int n;
    go();
    s_ready = 6'b0; mem_addr = 32'h0043_0000; mem_rstrb = 1'b1;
    n = 0;
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      go();
      mem_rstrb = 1'b0;
      #1;
      if (s_cs !== 6'b010000) break;
      n++;
    end
    checks++; if (n !== 15) $display("FAIL tmo_wait_cycles: got %0d want 15", n); else passed++;
    checks++; if ({mem_rbusy, err_flag, mem_rdata} !== {2'b11, 32'h6666_6666}) $display("FAIL tmo_err: got rb=%b flag=%b data=%h want 1 1 66666666", mem_rbusy, err_flag, mem_rdata); else passed++;
    checks++; if (err_addr !== 32'h0043_0000) $display("FAIL tmo_addr: got %h want 00430000", err_addr); else passed++;
    err_clr = 1'b1;
    go();
    err_clr = 1'b0;
    #1;
    checks++; if ({err_flag, mem_rbusy} !== 2'b00) $display("FAIL tmo_clr: got flag=%b rb=%b want 0 0", err_flag, mem_rbusy); else passed++;
`else
    for (int i = 0; i < 20; i++) begin
      go();
      mem_rstrb = 1'b0;
      #1;
      if (s_cs !== 6'b010000) break;
      n++;
    end
    checks++; if (n !== 20) $display("FAIL notmo_wait_cycles: got %0d want 20", n); else passed++;
    s_ready = 6'b010000;
    go();
    s_ready = 6'b0;
    #1;
    checks++; if ({mem_rbusy, err_flag, mem_rdata} !== {2'b00, 32'h5000_0004}) $display("FAIL notmo_done: got rb=%b flag=%b data=%h want 0 0 50000004", mem_rbusy, err_flag, mem_rdata); else passed++;
`endif
  endtask

  task automatic test_reset_mid_wait;
    go();
    s_ready = 6'b0; mem_addr = 32'h0041_0000; mem_rstrb = 1'b1;
    go();
    #1;
    checks++; if (s_cs !== 6'b000100) $display("FAIL rmw_wait: got %b want 000100", s_cs); else passed++;
    resetn = 1'b0;
    #1;
    checks++; if ({s_cs, s_rd, mem_rbusy} !== 8'b0) $display("FAIL rmw_async: got cs=%b rd=%b rb=%b want 000000 0 0", s_cs, s_rd, mem_rbusy); else passed++;
    checks++; if ({mem_rdata, err_addr} !== 64'h0) $display("FAIL rmw_regs: got %h/%h want 0/0", mem_rdata, err_addr); else passed++;
    go();
    resetn = 1'b1; s_ready = 6'b000100;
    go();
    mem_rstrb = 1'b0;
    go();
    #1;
    checks++; if ({mem_rbusy, mem_rdata} !== {1'b0, 32'h3000_0002}) $display("FAIL rmw_read: got rb=%b data=%h want 0 30000002", mem_rbusy, mem_rdata); else passed++;
  endtask

  task automatic test_both;
    go();
    s_ready = 6'b0; mem_addr = 32'h0042_0000; mem_rstrb = 1'b1; mem_wmask = 4'h1;
    #1;
    checks++; if ({mem_wbusy, mem_rbusy} !== 2'b10) $display("FAIL both_req: got wb=%b rb=%b want 1 0", mem_wbusy, mem_rbusy); else passed++;
    go();
    mem_rstrb = 1'b0; mem_wmask = 4'h0;
    #1;
    checks++; if ({s_cs, s_wr, s_rd, s_wmask} !== 12'b001000_1_0_0001) $display("FAIL both_wait: got cs=%b wr=%b rd=%b wm=%h want 001000 1 0 1", s_cs, s_wr, s_rd, s_wmask); else passed++;
    s_ready = 6'b001000;
    go();
    s_ready = 6'b0;
    #1;
    checks++; if ({mem_wbusy, mem_rdata} !== {1'b0, 32'h3000_0002}) $display("FAIL both_done: got wb=%b data=%h want 0 30000002", mem_wbusy, mem_rdata); else passed++;
  endtask

  initial begin
    for (int k = 0; k < 6; k++) s_rdata[k*32 +: 32] = 32'h1000_0000 * (k + 1) + k;
    test_reset();
    test_read_ram();
    test_write_slot1();
    test_unmapped();
    test_decode();
    test_err_clr();
    test_timeout();
    test_reset_mid_wait();
    test_both();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/periph_bus_decoder.md
PERIPH_BUS_DECODER -- requirements
Module: periph_bus_decoder

Interface
REQ-001 The module SHALL have parameter N_SLAVES, default 6, meaning the slave-port count; slot 0 is RAM/default and N_SLAVES ranges 2..16.
REQ-002 The module SHALL have parameter BASE_PAGE, default 16'h0040, meaning the first peripheral page, compared against mem_addr[31:16].
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the WAIT cycles allowed before an error response.
REQ-004 The module SHALL have parameter ERR_DATA, default 32'h6666_6666, meaning the read data returned on error.
REQ-005 The module SHALL have port clk, input, 1, the single system clock.
REQ-006 The module SHALL have port resetn, input, 1, the reset, which is asynchronous and active-low.
REQ-007 The module SHALL have master-side ports mem_addr in 32, mem_wdata in 32, mem_wmask in 4, mem_rstrb in 1, mem_rdata out 32, mem_rbusy out 1, and mem_wbusy out 1.
REQ-008 The module SHALL have slave-side ports s_cs out N_SLAVES (one-hot), s_rd out 1, s_wr out 1, s_wmask out 4, s_rdata in N_SLAVES*32 (slot k at bits [32k+31:32k]), and s_ready in N_SLAVES.
REQ-009 The module SHALL have status ports err_flag out 1 (sticky), err_addr out 32, and err_clr in 1.

Function
REQ-010 Address decoding SHALL map page p = mem_addr[31:16] as follows.
- BASE_PAGE <= p <= BASE_PAGE+N_SLAVES-2 maps to slot p-BASE_PAGE+1.
- BASE_PAGE+N_SLAVES-1 <= p <= BASE_PAGE+15 is unmapped.
- All other pages map to slot 0.
REQ-011 A request SHALL be defined as mem_rstrb or |mem_wmask, sampled in IDLE; when both are present, the write wins and s_rd stays 0.
REQ-012 The FSM SHALL have states IDLE, WAIT and ERR.
- IDLE with a mapped request goes to WAIT and latches the slot, address and wmask.
- IDLE with an unmapped request goes to ERR.
- WAIT with s_ready[slot] goes to IDLE.
- WAIT with the timeout expired goes to ERR.
- ERR goes to IDLE after 1 cycle.
REQ-013 In WAIT, s_cs SHALL be one-hot at the latched slot, and s_rd/s_wr/s_wmask SHALL be held from the latched request; in IDLE and ERR, s_cs, s_rd, s_wr and s_wmask SHALL all be 0.
REQ-014 mem_rbusy (for a read) or mem_wbusy (for a write) SHALL assert combinationally in the request cycle and stay high through WAIT and ERR; it SHALL be low in the cycle after the completion edge.
REQ-015 On completion of a read, mem_rdata SHALL be registered from s_rdata[slot] on the edge where s_ready is seen, and held until the next read completes.
REQ-016 An access of minimum latency SHALL give 1 busy cycle in IDLE plus 1 WAIT cycle with s_ready=1, i.e. data valid 2 cycles after the request.
REQ-017 On an error (unmapped or timeout), mem_rdata SHALL be ERR_DATA, err_flag SHALL be set, and err_addr SHALL be set to the latched address; write side effects SHALL be none.
REQ-018 err_clr SHALL clear err_flag; if err_clr coincides with a new error, the set wins; err_addr SHALL hold its last value.
REQ-019 Requests arriving in WAIT or ERR SHALL be ignored, since the master is stalled.
REQ-020 s_ready on any non-selected slot SHALL be ignored.

Reset
REQ-021 On resetn=0, at any time including mid-WAIT, the state SHALL go to IDLE and these outputs SHALL reset as follows:
- s_cs=0, s_rd=0, s_wr=0, s_wmask=0;
- mem_rdata=0;
- err_flag=0, err_addr=0;
- timeout counter=0.
REQ-022 mem_rbusy/mem_wbusy SHALL be 0 while resetn=0.

Configuration
REQ-023 With BUS_TIMEOUT_EN defined, a counter SHALL count WAIT cycles, and reaching TIMEOUT_CYCLES SHALL force ERR.
REQ-024 Without BUS_TIMEOUT_EN, WAIT SHALL persist until s_ready, and ERR SHALL be reachable only via an unmapped page.

Structure
REQ-025 Package soc_bus_pkg SHALL hold the FSM state typedef, the ERR_DATA default, the BASE_PAGE default and the window size constant (16).
REQ-026 The timeout counter SHALL be sub-module bus_timeout_counter, with ports clk, resetn, clear and en, and output expired; it is instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Read at 0x0000_0100 with s_ready[0]=1 immediately -> s_cs=6'b000001, mem_rdata = slot-0 data 2 cycles after the request, mem_rbusy high exactly 2 cycles.
- Write at 0x0040_0000 with wmask=4'hF, s_ready[1] after 3 cycles -> s_cs=6'b000010, s_wr=1 for 3 cycles, mem_wbusy low after completion.
- Read at 0x0046_0000 (unmapped, N_SLAVES=6) -> mem_rdata=32'h6666_6666, err_flag=1, err_addr=0x0046_0000, no s_cs asserted.
- BUS_TIMEOUT_EN defined, read at 0x0043_0000 with s_ready held 0 -> ERR after 15 WAIT cycles, ERR_DATA returned; then err_clr=1 -> err_flag=0.
- resetn pulsed low mid-WAIT -> s_cs=0 and busy=0 immediately; a subsequent read completes normally.
- mem_rstrb=1 and wmask=4'h1 in the same cycle -> s_wr=1, s_rd=0.
